// File: rtl/calc_port_arbiter_if.sv
// Bundle of the four request/response ports plus the shared ALU issue/return
// path. The arbiter attaches through the slave modport; whatever drives the
// requests and models the ALU uses the master modport.
interface calc_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
);
    logic [CMD_W-1:0]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
    logic [DATA_W-1:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
    logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
    logic              alu_valid;
    logic [CMD_W-1:0]  alu_cmd;
    logic [DATA_W-1:0] alu_op1, alu_op2;
    logic              alu_done;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  alu_done, alu_resp, alu_data,
        output out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4,
        output alu_valid, alu_cmd, alu_op1, alu_op2
    );

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output alu_done, alu_resp, alu_data,
        input  out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4,
        input  alu_valid, alu_cmd, alu_op1, alu_op2
    );
endinterface

// File: rtl/calc_port_arbiter.sv
// Four-port request sequencer in front of one shared ALU. Each port captures a
// two-cycle cmd/op1,op2 transfer, a round-robin arbiter picks one complete
// request at a time, issues it (or rejects an illegal command locally) and
// returns the result as a single-cycle pulse on the originating port.
module calc_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 16
) (
    input logic                c_clk,
    input logic                reset,
    calc_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND} port_st_t;
    typedef enum logic [1:0] {A_ARB, A_ISSUE, A_WAIT, A_RESP} arb_st_t;

    logic [3:0][CMD_W-1:0]  w_cmd_in;
    logic [3:0][DATA_W-1:0] w_data_in;
    logic [3:0]             w_pend;
    logic [3:0][CMD_W-1:0]  w_pcmd;
    logic [3:0][DATA_W-1:0] w_pop1;
    logic [3:0][DATA_W-1:0] w_pop2;

    arb_st_t                r_ast;
    logic [1:0]             r_last;
    logic [1:0]             r_gnt;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_alu_valid;
    logic [CMD_W-1:0]       r_alu_cmd;
    logic [DATA_W-1:0]      r_alu_op1;
    logic [DATA_W-1:0]      r_alu_op2;
    logic [3:0][1:0]        r_out_resp;
    logic [3:0][DATA_W-1:0] r_out_data;

    logic                   w_any;
    logic [1:0]             w_sel;
    logic                   w_legal;

    assign w_cmd_in  = {bus.req4_cmd_in, bus.req3_cmd_in, bus.req2_cmd_in, bus.req1_cmd_in};
    assign w_data_in = {bus.req4_data_in, bus.req3_data_in, bus.req2_data_in, bus.req1_data_in};

    // Per-port capture: cmd+op1, then op2, then hold until our response cycle.
    for (genvar i = 0; i < 4; i++) begin : g_port
        port_st_t          r_st;
        logic [CMD_W-1:0]  r_cmd;
        logic [DATA_W-1:0] r_op1;
        logic [DATA_W-1:0] r_op2;

        // Capture FSM; commands arriving outside IDLE are dropped silently.
        always_ff @(posedge c_clk or posedge reset) begin
            if (reset) begin
                r_st  <= P_IDLE;
                r_cmd <= '0;
                r_op1 <= '0;
                r_op2 <= '0;
            end else begin
                case (r_st)
                    P_IDLE: if (w_cmd_in[i] != '0) begin
                        r_cmd <= w_cmd_in[i];
                        r_op1 <= w_data_in[i];
                        r_st  <= P_OP2;
                    end
                    P_OP2: begin
                        r_op2 <= w_data_in[i];
                        r_st  <= P_PEND;
                    end
                    P_PEND: if (r_ast == A_RESP && r_gnt == 2'(i)) r_st <= P_IDLE;
                    default: r_st <= P_IDLE;
                endcase
            end
        end

        assign w_pend[i] = (r_st == P_PEND);
        assign w_pcmd[i] = r_cmd;
        assign w_pop1[i] = r_op1;
        assign w_pop2[i] = r_op2;
    end

    // Round-robin pick: first pending port after the last grant (wraps to last).
    always_comb begin
        w_any = 1'b0;
        w_sel = r_last;
        for (int k = 1; k <= 4; k++) begin
            if (!w_any && w_pend[r_last + 2'(k)]) begin
                w_any = 1'b1;
                w_sel = r_last + 2'(k);
            end
        end
    end

    assign w_legal = w_pcmd[w_sel] inside {CMD_W'(1), CMD_W'(2), CMD_W'(5), CMD_W'(6)};

    // Arbiter FSM; all outputs are registered single-cycle pulses.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_ast       <= A_ARB;
            r_last      <= 2'd3;
            r_gnt       <= 2'd0;
            r_cnt       <= '0;
            r_alu_valid <= 1'b0;
            r_alu_cmd   <= '0;
            r_alu_op1   <= '0;
            r_alu_op2   <= '0;
            r_out_resp  <= '0;
            r_out_data  <= '0;
        end else begin
            r_alu_valid <= 1'b0;
            r_alu_cmd   <= '0;
            r_alu_op1   <= '0;
            r_alu_op2   <= '0;
            r_out_resp  <= '0;
            r_out_data  <= '0;
            case (r_ast)
                A_ARB: if (w_any) begin
                    r_last <= w_sel;
                    r_gnt  <= w_sel;
                    if (w_legal) begin
                        r_alu_valid <= 1'b1;
                        r_alu_cmd   <= w_pcmd[w_sel];
                        r_alu_op1   <= w_pop1[w_sel];
                        r_alu_op2   <= w_pop2[w_sel];
                        r_ast       <= A_ISSUE;
                    end else begin
                        r_out_resp[w_sel] <= 2'd2;
                        r_ast             <= A_RESP;
                    end
                end
                A_ISSUE: begin
                    r_cnt <= '0;
                    r_ast <= A_WAIT;
                end
                A_WAIT: begin
                    // A done arriving on the last allowed cycle still wins.
                    if (bus.alu_done) begin
                        r_out_resp[r_gnt] <= bus.alu_resp;
                        r_out_data[r_gnt] <= bus.alu_data;
                        r_ast             <= A_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_out_resp[r_gnt] <= 2'd3;
                        r_ast             <= A_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_ast <= A_ARB;
            endcase
        end
    end

    assign bus.alu_valid = r_alu_valid;
    assign bus.alu_cmd   = r_alu_cmd;
    assign bus.alu_op1   = r_alu_op1;
    assign bus.alu_op2   = r_alu_op2;
    assign bus.out_resp1 = r_out_resp[0];
    assign bus.out_resp2 = r_out_resp[1];
    assign bus.out_resp3 = r_out_resp[2];
    assign bus.out_resp4 = r_out_resp[3];
    assign bus.out_data1 = r_out_data[0];
    assign bus.out_data2 = r_out_data[1];
    assign bus.out_data3 = r_out_data[2];
    assign bus.out_data4 = r_out_data[3];
endmodule

// File: tb/tb_calc_port_arbiter.sv
// Bench for calc_port_arbiter. A transaction-level reference works in absolute
// cycle numbers: when each request becomes pending, when the arbiter is next
// free, and when issue/done/response fall. It also plays the ALU.
module tb_calc_port_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_port_arbiter_if #(.DATA_W(DW), .CMD_W(CW)) bus();
  calc_port_arbiter #(.DATA_W(DW), .CMD_W(CW), .TIMEOUT(TO)) dut (
    .c_clk(clk), .reset(rst), .bus(bus.slave)
  );

  logic [3:0][CW-1:0] drv_cmd;
  logic [3:0][DW-1:0] drv_data;
  logic               drv_done;
  logic [1:0]         drv_aresp;
  logic [DW-1:0]      drv_adata;
  assign bus.req1_cmd_in  = drv_cmd[0];
  assign bus.req2_cmd_in  = drv_cmd[1];
  assign bus.req3_cmd_in  = drv_cmd[2];
  assign bus.req4_cmd_in  = drv_cmd[3];
  assign bus.req1_data_in = drv_data[0];
  assign bus.req2_data_in = drv_data[1];
  assign bus.req3_data_in = drv_data[2];
  assign bus.req4_data_in = drv_data[3];
  assign bus.alu_done     = drv_done;
  assign bus.alu_resp     = drv_aresp;
  assign bus.alu_data     = drv_adata;

  logic [3:0][1:0]    o_resp;
  logic [3:0][DW-1:0] o_data;
  assign o_resp = {bus.out_resp4, bus.out_resp3, bus.out_resp2, bus.out_resp1};
  assign o_data = {bus.out_data4, bus.out_data3, bus.out_data2, bus.out_data1};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference state, all times in cycles since reset release
  int          cyc;
  bit          p_out [4];
  int          p_acc [4];
  logic [CW-1:0] p_cmd [4];
  logic [DW-1:0] p_op1 [4];
  logic [DW-1:0] p_op2 [4];
  int          last, arb_at, iss_at, done_at, resp_at, resp_port, win_lo, win_hi;
  logic [CW-1:0] iss_cmd;
  logic [DW-1:0] iss_op1, iss_op2, done_data, resp_data;
  logic [1:0]  done_resp, resp_code;
  int          force_lat;   // -1 random, -2 never, else WAIT cycles before done
  bit          rnd_mode, stray_en, inj_done;

  task automatic m_reset();
    cyc = 0; last = 3; arb_at = 0;
    iss_at = -1; done_at = -1; resp_at = -1; win_lo = -1; win_hi = -2;
    for (int p = 0; p < 4; p++) p_out[p] = 0;
    drv_cmd = '0; drv_data = '0; drv_done = 0; drv_aresp = '0; drv_adata = '0;
  endtask

  function automatic int pick_lat();
    int r;
    if (force_lat == -2) return TO + 1;
    if (force_lat >= 0) return force_lat;
    r = $urandom_range(0, 9);
    if (r == 0) return TO + 1;
    if (r == 1) return TO;
    if (r == 2) return TO - 1;
    return $urandom_range(0, 4);
  endfunction

  // One clock cycle: check outputs, play the ALU, advance the reference.
  task automatic step();
    int found, q, lat;
    bit vld;
    vld = (cyc == iss_at);
    chk("alu_valid", bus.alu_valid, vld);
    chk("alu_cmd", bus.alu_cmd, vld ? iss_cmd : '0);
    chk("alu_op1", bus.alu_op1, vld ? iss_op1 : '0);
    chk("alu_op2", bus.alu_op2, vld ? iss_op2 : '0);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("out_resp%0d", p + 1), o_resp[p], (cyc == resp_at && p == resp_port) ? resp_code : 2'd0);
      chk($sformatf("out_data%0d", p + 1), o_data[p], (cyc == resp_at && p == resp_port) ? resp_data : '0);
    end
    drv_aresp = 2'($urandom_range(1, 2));
    drv_adata = $urandom;
    drv_done  = inj_done;
    if (cyc == done_at) begin
      drv_done = 1; drv_aresp = done_resp; drv_adata = done_data;
    end else if (stray_en && !(cyc >= win_lo && cyc <= win_hi) && $urandom_range(0, 7) == 0)
      drv_done = 1;
    for (int p = 0; p < 4; p++) begin
      if (p_out[p] && cyc == p_acc[p] + 1) p_op2[p] = drv_data[p];
      else if (!p_out[p] && drv_cmd[p] != '0) begin
        p_out[p] = 1; p_acc[p] = cyc; p_cmd[p] = drv_cmd[p]; p_op1[p] = drv_data[p];
      end
    end
    if (cyc == arb_at) begin
      found = -1;
      for (int k = 1; k <= 4; k++) begin
        q = (last + k) % 4;
        if (found < 0 && p_out[q] && p_acc[q] + 2 <= cyc) found = q;
      end
      if (found < 0) arb_at = cyc + 1;
      else begin
        last = found; resp_port = found;
        if (p_cmd[found] inside {4'd1, 4'd2, 4'd5, 4'd6}) begin
          iss_at = cyc + 1; iss_cmd = p_cmd[found];
          iss_op1 = p_op1[found]; iss_op2 = p_op2[found];
          win_lo = cyc + 2;
          lat = pick_lat();
          if (lat <= TO) begin
            done_at = cyc + 2 + lat; resp_at = cyc + 3 + lat;
            done_resp = rnd_mode ? 2'($urandom_range(1, 2)) : 2'd1;
            done_data = (iss_cmd == 4'd1) ? iss_op1 + iss_op2 : $urandom;
            resp_code = done_resp; resp_data = done_data;
          end else begin
            done_at = -1; resp_at = cyc + 3 + TO; resp_code = 2'd3; resp_data = '0;
          end
          win_hi = resp_at - 1;
        end else begin
          resp_at = cyc + 1; resp_code = 2'd2; resp_data = '0;
        end
        arb_at = resp_at + 1;
      end
    end
    if (cyc == resp_at) p_out[resp_port] = 0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    drv_cmd = '0;
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 4; p++) drv_data[p] = $urandom;
      step();
    end
  endtask

  // cmd on the given port mask, op1 then op2, then return to idle inputs
  task automatic req(input logic [3:0] mask, input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rnd_ops);
    for (int p = 0; p < 4; p++) begin
      drv_cmd[p]  = mask[p] ? c : '0;
      drv_data[p] = rnd_ops ? $urandom : a;
    end
    step();
    for (int p = 0; p < 4; p++) begin
      drv_cmd[p]  = '0;
      drv_data[p] = rnd_ops ? $urandom : b;
    end
    step();
  endtask

  task automatic rnd_drive();
    int r;
    for (int p = 0; p < 4; p++) begin
      drv_data[p] = $urandom;
      drv_cmd[p]  = '0;
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 5);
        case (r)
          0: drv_cmd[p] = 4'd1;
          1: drv_cmd[p] = 4'd2;
          2: drv_cmd[p] = 4'd5;
          3: drv_cmd[p] = 4'd6;
          default: drv_cmd[p] = 4'($urandom_range(1, 15));
        endcase
      end
    end
  endtask

  // Start a port-1 request and hit reset k cycles after its grant cycle.
  task automatic mid_reset(input int k);
    force_lat = -2;
    req(4'b0001, 4'd1, $urandom, $urandom, 0);
    for (int i = 0; i < k; i++) idle(1);
    #2 rst = 1'b1;
    #1;
    chk("rst_alu_valid", bus.alu_valid, 1'b0);
    chk("rst_alu_cmd", bus.alu_cmd, '0);
    chk("rst_out_resp", o_resp, '0);
    chk("rst_out_data", o_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    force_lat = -1; rnd_mode = 0; stray_en = 0; inj_done = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_alu_valid", bus.alu_valid, 1'b0);
    chk("reset_alu_ops", {bus.alu_cmd, bus.alu_op1, bus.alu_op2}, '0);
    chk("reset_out_resp", o_resp, '0);
    chk("reset_out_data", o_data, '0);
    rst = 1'b0;
    m_reset();

    // single add-style request, done 2 cycles after issue
    force_lat = 1;
    req(4'b0001, 4'd1, 32'd5, 32'd7, 0);
    idle(8);

    // all four at once, then ports 2 and 4
    force_lat = 0;
    req(4'b1111, 4'd2, '0, '0, 1);
    idle(24);
    req(4'b1010, 4'd2, '0, '0, 1);
    idle(12);

    // illegal command answered locally
    req(4'b0100, 4'd3, 32'd9, 32'd9, 0);
    idle(5);

    // ALU hang, stray done afterwards, then a normal request
    force_lat = -2;
    req(4'b0010, 4'd1, $urandom, $urandom, 0);
    idle(TO + 5);
    inj_done = 1; idle(1); inj_done = 0;
    force_lat = 1;
    req(4'b0010, 4'd1, $urandom, $urandom, 0);
    idle(8);

    // commands re-asserted while busy are dropped; next one right after the pulse
    force_lat = 2;
    drv_cmd = '0; drv_cmd[0] = 4'd5; drv_data[0] = $urandom; step();
    for (int i = 0; i < 7; i++) begin
      drv_cmd[0] = 4'd6; drv_data[0] = $urandom; step();
    end
    req(4'b0001, 4'd1, $urandom, $urandom, 0);
    idle(8);

    // random traffic with stray ALU strobes
    force_lat = -1; rnd_mode = 1; stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      rnd_drive();
      step();
    end
    drv_cmd = '0;
    rnd_mode = 0; stray_en = 0; force_lat = 0;
    idle(120);

    // reset during ISSUE, then during WAIT; late done ignored, port 4 still works
    mid_reset(1);
    mid_reset(4);
    inj_done = 1; idle(1); inj_done = 0;
    force_lat = 0;
    req(4'b1000, 4'd2, $urandom, $urandom, 0);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_port_arbiter.md
# calc_port_arbiter

Four-port request sequencer in front of a single shared calculator ALU. It captures two-cycle command/operand transfers on request ports 1–4, round-robin arbitrates among complete requests, and issues one operation at a time to the ALU. It returns each result on the originating port's out_resp/out_data pair as a one-cycle pulse. Invalid commands are answered locally, and a hung ALU is timed out.

## Interface
- DATA_W, 32, operand/result width
- CMD_W, 4, command width
- TIMEOUT, 16, max WAIT cycles before an error response (≥2)

- c_clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- reqN_cmd_in (N=1..4)  in  CMD_W  command; 0 = no request
- reqN_data_in (N=1..4)  in  DATA_W  op1 in command cycle, op2 in next cycle
- out_respN (N=1..4)  out  2  0 none, 1 success, 2 invalid/overflow, 3 timeout
- out_dataN (N=1..4)  out  DATA_W  result, valid only while out_respN≠0
- alu_valid  out  1  one-cycle issue strobe
- alu_cmd  out  CMD_W  command issued
- alu_op1, alu_op2  out  DATA_W  operands issued
- alu_done  in  1  ALU result strobe, sampled in WAIT only
- alu_resp  in  2  ALU response code (1 or 2)
- alu_data  in  DATA_W  ALU result

## Operation
- Per-port capture FSM: IDLE → OP2 → PEND.
  - IDLE with cmd≠0: latch cmd and op1, go to OP2.
  - OP2: latch op2 unconditionally and ignore cmd; go to PEND.
  - PEND holds until the port's response cycle, then returns to IDLE.
- Commands on a port in OP2 or PEND, or in its response cycle, are ignored and never answered. One outstanding request per port.
- Arbiter FSM has states ARB, ISSUE, WAIT, RESP.
  - ARB: if any port is PEND, grant the first PEND port in order last+1, last+2, last+3, last+4 (mod 4) and set last to that port. If cmd ∈ {1,2,5,6}, go to ISSUE; otherwise go to RESP with resp 2 and data 0.
  - ISSUE: alu_valid=1 with the granted cmd and operands; go to WAIT and clear the timeout counter.
  - WAIT: on alu_done, capture alu_resp/alu_data and go to RESP. Otherwise increment the counter; at TIMEOUT, go to RESP with resp 3 and data 0.
  - RESP: out_respG/out_dataG driven for this one cycle only; the granted port's capture FSM returns to IDLE; go to ARB.
- alu_done outside WAIT, including after a timeout, is ignored.
- alu_cmd/alu_op1/alu_op2 are 0 when alu_valid=0. Non-granted out_resp/out_data are 0.
- Data passes through unmodified. No arithmetic in this block.

## Timing
- Reset (async assert): all out_respN=0, out_dataN=0, alu_valid=0, alu_cmd/op=0, all capture FSMs IDLE, arbiter ARB, last=4 (port 1 has first priority), counter 0. The first edge after deassert behaves as an ARB cycle.
- Request with cmd at cycle T and op2 at T+1 is PEND from T+2.
- Valid command, arbiter idle: grant in ARB at T+2, alu_valid at T+3. alu_done in WAIT cycle D gives out_resp at D+1. Minimum ALU latency is 1 cycle, so the earliest out_resp is T+5.
- Invalid command: out_resp=2 at T+3, with no alu_valid.
- Timeout: out_resp=3 TIMEOUT+1 cycles after the first WAIT cycle when alu_done never arrives.
- A port may start a new command the cycle after its out_resp pulse.
- Simultaneous requests on all four ports after reset are served in order 1,2,3,4. Consecutive grants are separated by the RESP→ARB cycles.
- Reset during WAIT or RESP drops all pending work with no responses. A later alu_done is ignored, since the arbiter is in ARB.

## Test plan
- Port1 cmd=1, op1=5, op2=7; ALU returns done 2 cycles after alu_valid with resp 1, data 12 → alu_valid at T+3 with op1=5/op2=7; out_resp1=1, out_data1=12 for exactly one cycle at T+6; other ports 0.
- All four ports issue cmd=2 in the same cycle → alu_valid grants in order 1,2,3,4. Repeat with ports 2 and 4 only after the port-4 grant → order 2,4.
- Port3 cmd=3, data 9/9 → out_resp3=2, out_data3=0 at T+3; alu_valid never asserted.
- Port2 valid cmd; ALU never asserts alu_done → out_resp2=3 at the first WAIT cycle + TIMEOUT+1. An alu_done injected 2 cycles later is ignored, and the next request completes normally.
- Port1 cmd=5 pending; port1 cmd=6 re-asserted during OP2 and PEND → exactly one response (from cmd 5). A new cmd the cycle after the response is accepted.
- Assert reset mid-WAIT → all outputs 0 asynchronously. After release, a late alu_done produces no response; a fresh port4 request completes with out_resp4=1.
